// File: rtl/word_byte_serializer.sv
// word_byte_serializer
// Takes a BYTE_W*N_BYTES-bit word over a valid/ready handshake and emits its
// bytes one at a time, most significant byte first, over a second handshake.
// Build option: define WORD_BYTE_SER_BACK2BACK_EN to let a new word be taken
// on the same edge that the last byte of the current word is accepted. This
// removes the one-cycle bubble between words. Without it, in_ready is high
// only in IDLE.
module word_byte_serializer #(
    parameter  int BYTE_W  = 8,
    parameter  int N_BYTES = 4,
    localparam int WORD_W  = BYTE_W * N_BYTES,
    localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_next;

    logic w_send;
    logic w_last;
    logic w_load;

    assign w_send = (r_state == S_SEND);
    assign w_last = w_send && (r_idx == LAST_IDX);

    // The byte being presented is always the top lane of the shift register.
    assign out_valid = w_send;
    assign out_data  = w_send ? r_shift[WORD_W-1 -: BYTE_W] : '0;
    assign out_idx   = r_idx;
    assign out_last  = w_last;

`ifdef WORD_BYTE_SER_BACK2BACK_EN
    // The slot frees up as the last byte leaves, so ready follows out_ready.
    assign in_ready = (r_state == S_IDLE) || (w_last && out_ready);
`else
    assign in_ready = (r_state == S_IDLE);
`endif

    assign w_load = in_valid && in_ready;

    // Next-state logic: load a word, advance one byte per accepted output, or hold.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_idx_next   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_shift_next = in_data;
                    w_idx_next   = '0;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (!w_last) begin
                        w_shift_next = r_shift << BYTE_W;
                        w_idx_next   = r_idx + 1'b1;
                    end else begin
                        w_idx_next = '0;
                        if (w_load) begin
                            w_shift_next = in_data;
                        end else begin
                            w_shift_next = '0;
                            w_state_next = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_shift_next = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    // State registers. Reset discards any word that is still being sent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_idx   <= w_idx_next;
        end
    end

endmodule

// File: tb/tb_word_byte_serializer.sv
// tb_word_byte_serializer
// Reference model: a queue of the bytes still owed downstream. Accepting a
// word appends its bytes MSB first. Each accepted output byte pops one entry.
// The expected in_ready follows from the queue occupancy. The bench honours
// WORD_BYTE_SER_BACK2BACK_EN in the same way as the design.
module tb_word_byte_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_last;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [1:0] exp_idx_q[$];
    logic [7:0] got[$];

    word_byte_serializer #(.BYTE_W(8), .N_BYTES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs, check the outputs against the model,
    // and then advance the model on the edge. acc reports that a word was accepted.
    task automatic step(input logic rn, input logic iv, input logic [31:0] id,
                        input logic ordy, output logic acc);
        logic exp_val, exp_rdy;
        rst_n = rn; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        exp_val = (exp_q.size() != 0);
`ifdef WORD_BYTE_SER_BACK2BACK_EN
        exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
`else
        exp_rdy = (exp_q.size() == 0);
`endif
        acc = rn && iv && exp_rdy;
        if (rn) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_val});
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            if (exp_val) begin
                chk("out_data", {24'b0, out_data}, {24'b0, exp_q[0]});
                chk("out_idx", {30'b0, out_idx}, {30'b0, exp_idx_q[0]});
                chk("out_last", {31'b0, out_last}, {31'b0, exp_idx_q[0] == 2'd3});
            end else begin
                chk("out_last_idle", {31'b0, out_last}, 32'd0);
            end
            if (out_valid && ordy) got.push_back(out_data);
        end
        $display("t=%0t rst_n=%0b in_v=%0b in_d=%h in_r=%0b out_v=%0b out_r=%0b out_d=%h idx=%0d last=%0b",
                 $time, rn, iv, id, in_ready, out_valid, ordy, out_data, out_idx, out_last);
        @(posedge clk);
        if (!rn) begin
            exp_q.delete();
            exp_idx_q.delete();
        end else begin
            if (exp_val && ordy) begin
                void'(exp_q.pop_front());
                void'(exp_idx_q.pop_front());
            end
            if (acc) begin
                for (int b = 0; b < 4; b++) begin
                    exp_q.push_back(id[31-8*b -: 8]);
                    exp_idx_q.push_back(2'(b));
                end
            end
        end
        #1;
    endtask

    // Compare the first n logged output bytes with the top n bytes of w, then clear the log.
    task automatic expect_bytes(input string tag, input logic [31:0] w, input int n);
        logic [7:0] b;
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            b = (got.size() > i) ? got[i] : 8'hxx;
            chk({tag, "_byte"}, {24'b0, b}, {24'b0, w[31-8*i -: 8]});
        end
        got.delete();
    endtask

    initial begin
        logic acc;
        int n_acc, first_t, last_t;
        logic [31:0] d;

        // Reset for two cycles with in_valid high.
        step(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, acc);
        step(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, acc);
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_data", {24'b0, out_data}, 32'd0);
        chk("rst_out_idx", {30'b0, out_idx}, 32'd0);
        got.delete();

        // A single word with out_ready held high.
        step(1'b1, 1'b1, 32'hFFFE_FDF7, 1'b1, acc);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1, acc);
        expect_bytes("single", 32'hFFFE_FDF7, 4);

        // Backpressure with the out_ready pattern 1,0,0,1,...
        step(1'b1, 1'b1, 32'h1234_5678, 1'b0, acc);
        for (int i = 0; i < 24 && exp_q.size() != 0; i++)
            step(1'b1, 1'b0, 32'h0, (i % 3) == 0, acc);
        step(1'b1, 1'b0, 32'h0, 1'b1, acc);
        expect_bytes("bp", 32'h1234_5678, 4);

        // Back-to-back words with in_valid held high. Measure the span of the 8 bytes.
        n_acc = 0; first_t = -1; last_t = -1;
        for (int i = 0; i < 30 && got.size() < 8; i++) begin
            d = (n_acc == 0) ? 32'hA5A5_0001 : 32'hDEAD_BEEF;
            step(1'b1, n_acc < 2, d, 1'b1, acc);
            if (acc) n_acc++;
            if (got.size() == 1 && first_t < 0) first_t = i;
            if (got.size() == 8) last_t = i;
        end
`ifdef WORD_BYTE_SER_BACK2BACK_EN
        chk("b2b_span", last_t - first_t + 1, 8);
`else
        chk("b2b_span", last_t - first_t + 1, 9);
`endif
        got = got;
        begin
            logic [7:0] tail[$];
            tail = got[4:$];
            got = got[0:3];
            expect_bytes("b2b_w0", 32'hA5A5_0001, 4);
            got = tail;
            expect_bytes("b2b_w1", 32'hDEAD_BEEF, 4);
        end
        step(1'b1, 1'b0, 32'h0, 1'b1, acc);

        // Reset after the first two bytes have been accepted.
        step(1'b1, 1'b1, 32'hAABB_CCDD, 1'b1, acc);
        step(1'b1, 1'b0, 32'h0, 1'b1, acc);
        step(1'b1, 1'b0, 32'h0, 1'b1, acc);
        step(1'b0, 1'b0, 32'h0, 1'b1, acc);
        step(1'b1, 1'b0, 32'h0, 1'b1, acc);
        expect_bytes("midrst", 32'hAABB_CCDD, 2);
        step(1'b1, 1'b1, 32'h0102_0304, 1'b1, acc);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1, acc);
        expect_bytes("after_rst", 32'h0102_0304, 4);

        // A word presented while busy is ignored.
        step(1'b1, 1'b1, 32'h1122_3344, 1'b0, acc);
        n_acc = 0;
        for (int i = 0; i < 30 && (n_acc == 0 || exp_q.size() != 0); i++) begin
            if (exp_q.size() > 1 || n_acc != 0)
                step(1'b1, n_acc == 0, 32'hFFFF_FFFF, i[0], acc);
            else
                step(1'b1, 1'b1, 32'h5566_7788, i[0], acc);
            if (acc) n_acc++;
        end
        step(1'b1, 1'b0, 32'h0, 1'b1, acc);
        begin
            logic [7:0] tail[$];
            tail = (got.size() >= 4) ? got[4:$] : got;
            if (got.size() >= 4) got = got[0:3];
            expect_bytes("ign_w0", 32'h1122_3344, 4);
            got = tail;
            expect_bytes("ign_w1", 32'h5566_7788, 4);
        end

        // Randomized traffic with an occasional reset.
        for (int i = 0; i < 500; i++)
            step($urandom_range(63) != 0, $urandom_range(1), $urandom, $urandom_range(3) != 0, acc);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1, acc);
        chk("drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
